lsu_ctrl: RTL and testbench

- Consumer end of the micro-command path: executes the MREN/MWEN fields issued by the instruction decode lookup against a single-port data memory.
- Accepts one load/store command per transaction and drives a valid/ready memory request.
- Waits for the memory response, then aligns and extends load data.
- Returns one result beat to writeback with an error code.

---
 rtl/npc_micro_pkg.sv | 41 ++++
 rtl/lsu_lane_align.sv | 53 +++++
 rtl/lsu_ctrl.sv | 180 ++++++++++++++++++
 tb/tb_lsu_ctrl.sv | 366 ++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/npc_micro_pkg.sv
// Shared micro-command definitions for the decode lookup and the LSU.
// Provides the MREN/MWEN size codes, the LSU error code enum, the LSU
// state type and a misalignment helper.
package npc_micro_pkg;

    // Load size codes (MREN field)
    localparam logic [1:0] MREN_NONE = 2'b00;
    localparam logic [1:0] MREN_BYTE = 2'b01;
    localparam logic [1:0] MREN_HALF = 2'b10;
    localparam logic [1:0] MREN_WORD = 2'b11;

    // Store size codes (MWEN field), same encoding as MREN
    localparam logic [1:0] MWEN_NONE = 2'b00;
    localparam logic [1:0] MWEN_BYTE = 2'b01;
    localparam logic [1:0] MWEN_HALF = 2'b10;
    localparam logic [1:0] MWEN_WORD = 2'b11;

    typedef enum logic [1:0] {
        LSU_OK       = 2'b00,
        LSU_MISALIGN = 2'b01,
        LSU_TIMEOUT  = 2'b10,
        LSU_ILLEGAL  = 2'b11
    } lsu_err_e;

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_REQ  = 2'b01,
        ST_WAIT = 2'b10,
        ST_DONE = 2'b11
    } lsu_state_e;

    // Half accesses need addr[0]=0, word accesses need addr[1:0]=0.
    function automatic logic is_misaligned(input logic [1:0] size, input logic [1:0] off);
        logic bad;
        bad = 1'b0;
        if (size == MREN_HALF && off[0]) bad = 1'b1;
        if (size == MREN_WORD && off != 2'b00) bad = 1'b1;
        return bad;
    endfunction

endpackage

// File: rtl/lsu_lane_align.sv
// Combinational byte-lane alignment for the LSU.
// Ports:
//   size      - access size code (MREN/MWEN encoding)
//   off       - byte offset addr[1:0]
//   is_unsigned - zero-extend loads when 1, sign-extend when 0
//   wdata     - right-aligned store data
//   rdata     - raw word read from memory
//   wstrb     - byte-lane write strobes for a store of this size
//   wdata_sh  - store data shifted into its lanes
//   rdata_ext - load data shifted down and extended to 32 bits
module lsu_lane_align
    import npc_micro_pkg::*;
(
    input  logic [1:0]  size,
    input  logic [1:0]  off,
    input  logic        is_unsigned,
    input  logic [31:0] wdata,
    input  logic [31:0] rdata,
    output logic [3:0]  wstrb,
    output logic [31:0] wdata_sh,
    output logic [31:0] rdata_ext
);

    logic [31:0] rdata_sh;
    logic [4:0]  bit_sh;

    always_comb begin
        bit_sh    = {off, 3'b000};
        wdata_sh  = wdata << bit_sh;
        rdata_sh  = rdata >> bit_sh;
        wstrb     = 4'b0000;
        rdata_ext = 32'h0;
        unique case (size)
            MREN_BYTE: begin
                wstrb     = 4'b0001 << off;
                rdata_ext = {{24{~is_unsigned & rdata_sh[7]}}, rdata_sh[7:0]};
            end
            MREN_HALF: begin
                wstrb     = 4'b0011 << off;
                rdata_ext = {{16{~is_unsigned & rdata_sh[15]}}, rdata_sh[15:0]};
            end
            MREN_WORD: begin
                wstrb     = 4'b1111;
                rdata_ext = rdata_sh;
            end
            default: begin
                wstrb     = 4'b0000;
                rdata_ext = 32'h0;
            end
        endcase
    end

endmodule

// File: rtl/lsu_ctrl.sv
// Load/store unit controller: executes one MREN/MWEN micro-command per
// transaction against a single-port valid/ready data memory, then returns one
// result beat with aligned/extended load data and an error code.
// Ports:
//   clk, rst_n          - clock, synchronous active-low reset
//   cmd_*               - command handshake and fields from decode/ALU
//   mem_req_*           - memory request (word address, strobes, lane data)
//   mem_resp_*          - memory response / store ack
//   res_valid/rdata/err - one-cycle result pulse to writeback
module lsu_ctrl
    import npc_micro_pkg::*;
#(
    parameter int unsigned ADDR_W  = 32,
    parameter int unsigned DATA_W  = 32,
    parameter int unsigned TIMEOUT = 64
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              cmd_valid,
    output logic              cmd_ready,
    input  logic [1:0]        cmd_mren,
    input  logic [1:0]        cmd_mwen,
    input  logic              cmd_unsigned,
    input  logic [ADDR_W-1:0] cmd_addr,
    input  logic [DATA_W-1:0] cmd_wdata,
    output logic              mem_req_valid,
    input  logic              mem_req_ready,
    output logic [ADDR_W-1:0] mem_req_addr,
    output logic              mem_req_wen,
    output logic [3:0]        mem_req_wstrb,
    output logic [DATA_W-1:0] mem_req_wdata,
    input  logic              mem_resp_valid,
    input  logic [DATA_W-1:0] mem_resp_rdata,
    output logic              res_valid,
    output logic [DATA_W-1:0] res_rdata,
    output logic [1:0]        res_err
);

    localparam int unsigned      CNT_W = $clog2(TIMEOUT) + 1;
    localparam logic [CNT_W-1:0] LIMIT = CNT_W'(TIMEOUT - 1);

    lsu_state_e        state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [1:0]        off_q, off_d;
    logic [1:0]        size_q, size_d;
    logic              uns_q, uns_d;
    logic              store_q, store_d;
    logic [DATA_W-1:0] wdata_q, wdata_d;
    logic [DATA_W-1:0] res_rdata_q, res_rdata_d;
    lsu_err_e          res_err_q, res_err_d;

    logic [3:0]        al_wstrb;
    logic [DATA_W-1:0] al_wdata;
    logic [DATA_W-1:0] al_rdata;
    logic [1:0]        cmd_size;

    // Operates on latched fields so request outputs stay stable in REQ.
    lsu_lane_align u_align (
        .size        (size_q),
        .off         (off_q),
        .is_unsigned (uns_q),
        .wdata       (wdata_q),
        .rdata       (mem_resp_rdata),
        .wstrb       (al_wstrb),
        .wdata_sh    (al_wdata),
        .rdata_ext   (al_rdata)
    );

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        addr_d      = addr_q;
        off_d       = off_q;
        size_d      = size_q;
        uns_d       = uns_q;
        store_d     = store_q;
        wdata_d     = wdata_q;
        res_rdata_d = res_rdata_q;
        res_err_d   = res_err_q;
        cmd_size    = (cmd_mwen != MWEN_NONE) ? cmd_mwen : cmd_mren;

        unique case (state_q)
            ST_IDLE: begin
                if (cmd_valid) begin
                    addr_d  = {cmd_addr[ADDR_W-1:2], 2'b00};
                    off_d   = cmd_addr[1:0];
                    size_d  = cmd_size;
                    uns_d   = cmd_unsigned;
                    store_d = (cmd_mwen != MWEN_NONE);
                    wdata_d = cmd_wdata;
                    if (cmd_mren != MREN_NONE && cmd_mwen != MWEN_NONE) begin
                        state_d     = ST_DONE;
                        res_err_d   = LSU_ILLEGAL;
                        res_rdata_d = '0;
                    end else if (cmd_mren == MREN_NONE && cmd_mwen == MWEN_NONE) begin
                        state_d     = ST_DONE;
                        res_err_d   = LSU_OK;
                        res_rdata_d = '0;
                    end else if (is_misaligned(cmd_size, cmd_addr[1:0])) begin
                        state_d     = ST_DONE;
                        res_err_d   = LSU_MISALIGN;
                        res_rdata_d = '0;
                    end else begin
                        state_d = ST_REQ;
                        cnt_d   = '0;
                    end
                end
            end
            ST_REQ: begin
                cnt_d = cnt_q + CNT_W'(1);
                if (cnt_q == LIMIT) begin
                    state_d     = ST_DONE;
                    res_err_d   = LSU_TIMEOUT;
                    res_rdata_d = '0;
                end else if (mem_req_ready) begin
                    state_d = ST_WAIT;
                end
            end
            ST_WAIT: begin
                cnt_d = cnt_q + CNT_W'(1);
                // A response on the last allowed cycle still completes normally.
                if (mem_resp_valid) begin
                    state_d     = ST_DONE;
                    res_err_d   = LSU_OK;
                    res_rdata_d = store_q ? '0 : al_rdata;
                end else if (cnt_q == LIMIT) begin
                    state_d     = ST_DONE;
                    res_err_d   = LSU_TIMEOUT;
                    res_rdata_d = '0;
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q     <= ST_IDLE;
            cnt_q       <= '0;
            addr_q      <= '0;
            off_q       <= '0;
            size_q      <= '0;
            uns_q       <= 1'b0;
            store_q     <= 1'b0;
            wdata_q     <= '0;
            res_rdata_q <= '0;
            res_err_q   <= LSU_OK;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            addr_q      <= addr_d;
            off_q       <= off_d;
            size_q      <= size_d;
            uns_q       <= uns_d;
            store_q     <= store_d;
            wdata_q     <= wdata_d;
            res_rdata_q <= res_rdata_d;
            res_err_q   <= res_err_d;
        end
    end

    always_comb begin
        cmd_ready     = (state_q == ST_IDLE);
        mem_req_valid = (state_q == ST_REQ);
        res_valid     = (state_q == ST_DONE);
        mem_req_addr  = addr_q;
        mem_req_wen   = store_q;
        mem_req_wstrb = store_q ? al_wstrb : 4'b0000;
        mem_req_wdata = store_q ? al_wdata : '0;
        res_rdata     = res_rdata_q;
        res_err       = res_err_q;
    end

endmodule

// File: tb/tb_lsu_ctrl.sv
module tb_lsu_ctrl;

    logic        clk;
    logic        rst_n;
    logic        cmd_valid;
    logic        cmd_ready;
    logic [1:0]  cmd_mren;
    logic [1:0]  cmd_mwen;
    logic        cmd_unsigned;
    logic [31:0] cmd_addr;
    logic [31:0] cmd_wdata;
    logic        mem_req_valid;
    logic        mem_req_ready;
    logic [31:0] mem_req_addr;
    logic        mem_req_wen;
    logic [3:0]  mem_req_wstrb;
    logic [31:0] mem_req_wdata;
    logic        mem_resp_valid;
    logic [31:0] mem_resp_rdata;
    logic        res_valid;
    logic [31:0] res_rdata;
    logic [1:0]  res_err;

    int tests;
    int fails;

    lsu_ctrl #(
        .ADDR_W  (32),
        .DATA_W  (32),
        .TIMEOUT (64)
    ) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .cmd_valid      (cmd_valid),
        .cmd_ready      (cmd_ready),
        .cmd_mren       (cmd_mren),
        .cmd_mwen       (cmd_mwen),
        .cmd_unsigned   (cmd_unsigned),
        .cmd_addr       (cmd_addr),
        .cmd_wdata      (cmd_wdata),
        .mem_req_valid  (mem_req_valid),
        .mem_req_ready  (mem_req_ready),
        .mem_req_addr   (mem_req_addr),
        .mem_req_wen    (mem_req_wen),
        .mem_req_wstrb  (mem_req_wstrb),
        .mem_req_wdata  (mem_req_wdata),
        .mem_resp_valid (mem_resp_valid),
        .mem_resp_rdata (mem_resp_rdata),
        .res_valid      (res_valid),
        .res_rdata      (res_rdata),
        .res_err        (res_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Advance one clock; inputs and samples are taken 1ns after the edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic issue(input logic [1:0] mren, input logic [1:0] mwen, input logic uns,
                         input logic [31:0] addr, input logic [31:0] wdata);
        cmd_valid    = 1'b1;
        cmd_mren     = mren;
        cmd_mwen     = mwen;
        cmd_unsigned = uns;
        cmd_addr     = addr;
        cmd_wdata    = wdata;
        tick();
        cmd_valid    = 1'b0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        tick();
        tick();
        tests++;
        if (cmd_ready !== 1'b1 || mem_req_valid !== 1'b0 || res_valid !== 1'b0 ||
            res_err !== 2'b00 || res_rdata !== 32'h0 || mem_req_wstrb !== 4'h0) begin
            $display("FAIL reset: ready=%b reqv=%b resv=%b err=%b rdata=%h strb=%b (want 1 0 0 00 0 0)",
                     cmd_ready, mem_req_valid, res_valid, res_err, res_rdata, mem_req_wstrb);
            fails++;
        end
        rst_n = 1'b1;
        tick();
    endtask

    task automatic test_lb();
        mem_req_ready = 1'b1;
        issue(2'b01, 2'b00, 1'b0, 32'h8000_0003, 32'h0);   // cycle 1: REQ
        tests++;
        if (mem_req_valid !== 1'b1 || mem_req_addr !== 32'h8000_0000 || mem_req_wen !== 1'b0 ||
            mem_req_wstrb !== 4'b0000) begin
            $display("FAIL lb_req: v=%b addr=%h wen=%b strb=%b (want 1 80000000 0 0000)",
                     mem_req_valid, mem_req_addr, mem_req_wen, mem_req_wstrb);
            fails++;
        end
        tick();                                              // cycle 2: WAIT
        tests++;
        if (mem_req_valid !== 1'b0 || res_valid !== 1'b0) begin
            $display("FAIL lb_wait: reqv=%b resv=%b (want 0 0)", mem_req_valid, res_valid);
            fails++;
        end
        mem_resp_valid = 1'b1;
        mem_resp_rdata = 32'h80FF_0000;
        tick();                                              // cycle 3: DONE
        mem_resp_valid = 1'b0;
        tests++;
        if (res_valid !== 1'b1 || res_rdata !== 32'hFFFF_FF80 || res_err !== 2'b00) begin
            $display("FAIL lb_res: v=%b rdata=%h err=%b (want 1 ffffff80 00)",
                     res_valid, res_rdata, res_err);
            fails++;
        end
        tick();
        tests++;
        if (res_valid !== 1'b0 || cmd_ready !== 1'b1) begin
            $display("FAIL lb_pulse: resv=%b ready=%b (want 0 1)", res_valid, cmd_ready);
            fails++;
        end
    endtask

    task automatic test_load_sizes();
        logic [1:0]  v_mren [3];
        logic        v_uns  [3];
        logic [31:0] v_addr [3];
        logic [31:0] v_rd   [3];
        logic [31:0] v_exp  [3];
        v_mren[0] = 2'b01; v_uns[0] = 1'b1; v_addr[0] = 32'h0000_0011;
        v_rd[0] = 32'h0000_AB00; v_exp[0] = 32'h0000_00AB;
        v_mren[1] = 2'b10; v_uns[1] = 1'b0; v_addr[1] = 32'h0000_0022;
        v_rd[1] = 32'h8001_0000; v_exp[1] = 32'hFFFF_8001;
        v_mren[2] = 2'b10; v_uns[2] = 1'b1; v_addr[2] = 32'h0000_0030;
        v_rd[2] = 32'h1234_F00D; v_exp[2] = 32'h0000_F00D;
        mem_req_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            issue(v_mren[i], 2'b00, v_uns[i], v_addr[i], 32'h0);
            tick();
            mem_resp_valid = 1'b1;
            mem_resp_rdata = v_rd[i];
            tick();
            mem_resp_valid = 1'b0;
            tests++;
            if (res_valid !== 1'b1 || res_rdata !== v_exp[i] || res_err !== 2'b00) begin
                $display("FAIL load_size[%0d]: v=%b rdata=%h err=%b (want 1 %h 00)",
                         i, res_valid, res_rdata, res_err, v_exp[i]);
                fails++;
            end
            tick();
        end
    endtask

    task automatic test_sh();
        mem_req_ready = 1'b1;
        issue(2'b00, 2'b10, 1'b0, 32'h0000_0102, 32'h1234_ABCD);
        tests++;
        if (mem_req_valid !== 1'b1 || mem_req_addr !== 32'h0000_0100 || mem_req_wen !== 1'b1 ||
            mem_req_wstrb !== 4'b1100 || mem_req_wdata !== 32'hABCD_0000) begin
            $display("FAIL sh_req: v=%b addr=%h wen=%b strb=%b wdata=%h (want 1 100 1 1100 abcd0000)",
                     mem_req_valid, mem_req_addr, mem_req_wen, mem_req_wstrb, mem_req_wdata);
            fails++;
        end
        tick();
        mem_resp_valid = 1'b1;
        mem_resp_rdata = 32'h5555_5555;
        tick();
        mem_resp_valid = 1'b0;
        tests++;
        if (res_valid !== 1'b1 || res_rdata !== 32'h0 || res_err !== 2'b00) begin
            $display("FAIL sh_res: v=%b rdata=%h err=%b (want 1 0 00)", res_valid, res_rdata, res_err);
            fails++;
        end
        tick();
    endtask

    task automatic test_sb_lane();
        mem_req_ready = 1'b0;
        issue(2'b00, 2'b01, 1'b0, 32'h0000_0201, 32'h0000_00A5);
        tests++;
        if (mem_req_wstrb !== 4'b0010 || mem_req_wdata !== 32'h0000_A500) begin
            $display("FAIL sb_lane: strb=%b wdata=%h (want 0010 0000a500)", mem_req_wstrb, mem_req_wdata);
            fails++;
        end
        mem_req_ready = 1'b1;
        tick();
        mem_resp_valid = 1'b1;
        tick();
        mem_resp_valid = 1'b0;
        tick();
    endtask

    task automatic test_misalign();
        int seen;
        seen = 0;
        issue(2'b11, 2'b00, 1'b0, 32'h0000_0402, 32'h0);
        if (mem_req_valid) seen++;
        tests++;
        if (res_valid !== 1'b1 || res_err !== 2'b01 || res_rdata !== 32'h0) begin
            $display("FAIL misalign_res: v=%b err=%b rdata=%h (want 1 01 0)", res_valid, res_err, res_rdata);
            fails++;
        end
        tick();
        if (mem_req_valid) seen++;
        tests++;
        if (seen !== 0 || res_valid !== 1'b0) begin
            $display("FAIL misalign_noreq: req_cycles=%0d resv=%b (want 0 0)", seen, res_valid);
            fails++;
        end
    endtask

    task automatic test_illegal_noop();
        issue(2'b01, 2'b01, 1'b0, 32'h0000_0500, 32'h0);
        tests++;
        if (res_valid !== 1'b1 || res_err !== 2'b11 || mem_req_valid !== 1'b0) begin
            $display("FAIL illegal: v=%b err=%b reqv=%b (want 1 11 0)", res_valid, res_err, mem_req_valid);
            fails++;
        end
        tick();
        issue(2'b00, 2'b00, 1'b0, 32'h0000_0600, 32'h0);
        tests++;
        if (res_valid !== 1'b1 || res_err !== 2'b00 || res_rdata !== 32'h0 || mem_req_valid !== 1'b0) begin
            $display("FAIL noop: v=%b err=%b rdata=%h reqv=%b (want 1 00 0 0)",
                     res_valid, res_err, res_rdata, mem_req_valid);
            fails++;
        end
        tick();
    endtask

    task automatic test_stall();
        int bad;
        bad = 0;
        mem_req_ready = 1'b0;
        issue(2'b11, 2'b00, 1'b1, 32'h0000_0200, 32'h0);
        for (int i = 0; i < 10; i++) begin
            if (mem_req_valid !== 1'b1 || mem_req_addr !== 32'h0000_0200 ||
                mem_req_wen !== 1'b0 || mem_req_wstrb !== 4'b0000) bad++;
            tick();
        end
        tests++;
        if (bad !== 0) begin
            $display("FAIL stall_stable: unstable_cycles=%0d (want 0)", bad);
            fails++;
        end
        mem_req_ready = 1'b1;
        tests++;
        if (mem_req_valid !== 1'b1) begin
            $display("FAIL stall_hold: reqv=%b (want 1)", mem_req_valid);
            fails++;
        end
        tick();
        mem_resp_valid = 1'b1;
        mem_resp_rdata = 32'hDEAD_BEEF;
        tick();
        mem_resp_valid = 1'b0;
        tests++;
        if (res_valid !== 1'b1 || res_rdata !== 32'hDEAD_BEEF || res_err !== 2'b00) begin
            $display("FAIL stall_res: v=%b rdata=%h err=%b (want 1 deadbeef 00)",
                     res_valid, res_rdata, res_err);
            fails++;
        end
        tick();
    endtask

    task automatic test_mid_reset();
        mem_req_ready = 1'b1;
        issue(2'b11, 2'b00, 1'b0, 32'h0000_0400, 32'h0);
        tick();                                              // WAIT
        rst_n = 1'b0;
        tick();
        tests++;
        if (cmd_ready !== 1'b1 || mem_req_valid !== 1'b0 || res_valid !== 1'b0 ||
            res_rdata !== 32'h0 || res_err !== 2'b00 || mem_req_addr !== 32'h0) begin
            $display("FAIL midreset_clear: ready=%b reqv=%b resv=%b rdata=%h err=%b addr=%h (want 1 0 0 0 00 0)",
                     cmd_ready, mem_req_valid, res_valid, res_rdata, res_err, mem_req_addr);
            fails++;
        end
        rst_n = 1'b1;
        mem_resp_valid = 1'b1;
        mem_resp_rdata = 32'h1111_2222;
        tick();
        mem_resp_valid = 1'b0;
        tests++;
        if (res_valid !== 1'b0 || cmd_ready !== 1'b1) begin
            $display("FAIL midreset_drop: resv=%b ready=%b (want 0 1)", res_valid, cmd_ready);
            fails++;
        end
        tick();
        tests++;
        if (res_valid !== 1'b0 || cmd_ready !== 1'b1) begin
            $display("FAIL midreset_idle: resv=%b ready=%b (want 0 1)", res_valid, cmd_ready);
            fails++;
        end
    endtask

    task automatic test_timeout();
        int n;
        n = 0;
        mem_req_ready = 1'b1;
        issue(2'b10, 2'b00, 1'b1, 32'h0000_0300, 32'h0);     // now in REQ
        while (res_valid !== 1'b1 && n < 200) begin
            tick();
            n++;
        end
        tests++;
        if (n !== 64) begin
            $display("FAIL timeout_latency: cycles=%0d (want 64)", n);
            fails++;
        end
        tests++;
        if (res_valid !== 1'b1 || res_err !== 2'b10 || res_rdata !== 32'h0) begin
            $display("FAIL timeout_res: v=%b err=%b rdata=%h (want 1 10 0)", res_valid, res_err, res_rdata);
            fails++;
        end
        mem_resp_valid = 1'b1;
        mem_resp_rdata = 32'hCAFE_F00D;
        tick();
        mem_resp_valid = 1'b0;
        tests++;
        if (res_valid !== 1'b0 || cmd_ready !== 1'b1) begin
            $display("FAIL timeout_late: resv=%b ready=%b (want 0 1)", res_valid, cmd_ready);
            fails++;
        end
        tick();
        tests++;
        if (res_valid !== 1'b0) begin
            $display("FAIL timeout_second: resv=%b (want 0)", res_valid);
            fails++;
        end
    endtask

    initial begin
        tests          = 0;
        fails          = 0;
        rst_n          = 1'b0;
        cmd_valid      = 1'b0;
        cmd_mren       = 2'b00;
        cmd_mwen       = 2'b00;
        cmd_unsigned   = 1'b0;
        cmd_addr       = 32'h0;
        cmd_wdata      = 32'h0;
        mem_req_ready  = 1'b0;
        mem_resp_valid = 1'b0;
        mem_resp_rdata = 32'h0;
        #1;
        test_reset();
        test_lb();
        test_load_sizes();
        test_sh();
        test_sb_lane();
        test_misalign();
        test_illegal_noop();
        test_stall();
        test_mid_reset();
        test_timeout();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
